count_seq_checker: RTL and testbench

//  Receive-side monitor for the free-running counter's count_value bus. Samples the bus each clk,

---
 rtl/count_seq_checker.sv | 151 +++++++++++++++
 tb/tb_count_seq_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Monitors a free-running counter bus: locks on, checks each sample is previous+1, counts errors and wraps.
// Optional stall detection is built when STALL_DETECT_EN is defined.
module count_seq_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOSS_LIMIT = 3
`ifdef STALL_DETECT_EN
  , parameter int unsigned STALL_LIMIT = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic [WIDTH-1:0] count_value,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [15:0]      wrap_count,
  output logic [WIDTH-1:0] expected,
  output logic             stall
);

  localparam int unsigned MISS_W = $clog2(LOSS_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [15:0]      wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             stall_q, stall_d;

  logic              match_c;
  logic [MISS_W-1:0] miss_inc_c;
  logic              loss_c;

  assign match_c    = (count_value == expected_q);
  assign miss_inc_c = MISS_W'(miss_q + MISS_W'(1));
  assign loss_c     = !match_c && (miss_inc_c >= MISS_W'(LOSS_LIMIT));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; check_en low always wins
  always_comb begin
    state_d = state_q;
    if (!check_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ACQ;
        ST_ACQ:  state_d = ST_LOCK;
        ST_LOCK: if (loss_c) state_d = ST_ACQ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    locked_d     = (state_d == ST_LOCK);
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    expected_d   = expected_q;
    miss_d       = '0;
    if (check_en) begin
      case (state_q)
        ST_ACQ: expected_d = count_value + WIDTH'(1);
        ST_LOCK: begin
          if (match_c) begin
            expected_d = expected_q + WIDTH'(1);
            if (count_value == '0) wrap_count_d = wrap_count_q + 16'd1;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            expected_d = count_value + WIDTH'(1);
            miss_d     = loss_c ? '0 : miss_inc_c;
          end
        end
        default: miss_d = '0;
      endcase
    end
  end

`ifdef STALL_DETECT_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  logic [WIDTH-1:0]   prev_q;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Run of repeated samples, only tracked while staying in LOCK
  always_comb begin
    stall_cnt_d = '0;
    if (check_en && (state_q == ST_LOCK) && !loss_c && (count_value == prev_q)) begin
      if (stall_cnt_q != STALL_W'(STALL_LIMIT)) stall_cnt_d = STALL_W'(stall_cnt_q + STALL_W'(1));
      else                                      stall_cnt_d = stall_cnt_q;
    end
    stall_d = (stall_cnt_d >= STALL_W'(STALL_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      prev_q      <= count_value;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  always_comb stall_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      expected_q   <= '0;
      stall_q      <= 1'b0;
    end else begin
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      expected_q   <= expected_d;
      stall_q      <= stall_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomized self-checking bench for count_seq_checker against a sample-by-sample reference model.
module tb_count_seq_checker;

  localparam int unsigned LOSS_LIMIT  = 3;
  localparam int unsigned STALL_LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       check_en;
  logic [7:0] count_value;
  logic       locked;
  logic       err_pulse;
  logic [15:0] err_count;
  logic [15:0] wrap_count;
  logic [7:0] expected;
  logic       stall;

  count_seq_checker dut (
    .clk         (clk),
    .reset       (reset),
    .check_en    (check_en),
    .count_value (count_value),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .wrap_count  (wrap_count),
    .expected    (expected),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = idle, 1 = acquiring, 2 = locked
  int         m_mode;
  logic [7:0] m_exp;
  int         m_miss;
  int         m_err;
  int         m_wrap;
  bit         m_pulse;
  logic [7:0] m_prev;
  int         m_run;
  logic [7:0] cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 8'd0; m_miss = 0; m_err = 0; m_wrap = 0;
    m_pulse = 1'b0; m_prev = 8'd0; m_run = 0;
  endtask

  task automatic model_tick(input logic en, input logic [7:0] v);
    m_pulse = 1'b0;
    if (!en) begin
      m_mode = 0;
      m_miss = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_exp  = v + 8'd1;
      m_mode = 2;
    end else if (v == m_exp) begin
      if (v == 8'd0) m_wrap = (m_wrap + 1) % 65536;
      m_exp  = v + 8'd1;
      m_miss = 0;
    end else begin
      m_pulse = 1'b1;
      if (m_err < 65535) m_err++;
      m_exp = v + 8'd1;
      m_miss++;
      if (m_miss == LOSS_LIMIT) begin
        m_mode = 1;
        m_miss = 0;
      end
    end
    if (en && m_mode == 2 && v == m_prev) m_run++;
    else                                  m_run = 0;
    m_prev = v;
  endtask

  task automatic check_all();
    bit exp_stall;
`ifdef STALL_DETECT_EN
    exp_stall = (m_run >= STALL_LIMIT);
`else
    exp_stall = 1'b0;
`endif
    check("locked",     32'(locked),     32'(m_mode == 2));
    check("err_pulse",  32'(err_pulse),  32'(m_pulse));
    check("err_count",  32'(err_count),  32'(m_err));
    check("wrap_count", 32'(wrap_count), 32'(m_wrap));
    check("expected",   32'(expected),   32'(m_exp));
    check("stall",      32'(stall),      32'(exp_stall));
  endtask

  task automatic step(input logic en, input logic [7:0] v);
    check_en    = en;
    count_value = v;
    cur         = v;
    @(posedge clk);
    model_tick(en, v);
    #1;
    check_all();
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) step(1'b1, cur + 8'd1);
  endtask

  initial begin
    reset = 1'b1; check_en = 1'b0; count_value = 8'd0; cur = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();

    // Clean count from 0 after reset release
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i));

    // Jump to near the top, then run through the all-ones wrap
    step(1'b1, 8'd245);
    run_seq(16);

    // Single glitch while locked, then follow the new value
    step(1'b1, m_exp);
    step(1'b1, m_exp + 8'd40);
    run_seq(4);

    // LOSS_LIMIT consecutive mismatches drop lock, then relock
    for (int i = 0; i < LOSS_LIMIT; i++) step(1'b1, m_exp + 8'(1 + $urandom_range(0, 200)));
    run_seq(6);

    // Mismatching sample on the edge check_en drops is ignored
    step(1'b0, m_exp + 8'd9);
    step(1'b0, cur + 8'd1);
    run_seq(5);

    // Held value
    for (int i = 0; i < 6; i++) step(1'b1, cur);
    run_seq(3);

    // Randomized traffic: mostly counting, some jumps, holds and enable drops
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic en;
      logic [7:0] v;
      r  = int'($urandom_range(0, 99));
      en = ($urandom_range(0, 99) >= 4);
      if (r < 80)      v = cur + 8'd1;
      else if (r < 90) v = 8'($urandom);
      else             v = cur;
      step(en, v);
    end

    // Asynchronous reset mid-cycle clears outputs before the next edge
    run_seq(4);
    reset = 1'b1;
    #3;
    model_reset();
    check_all();
    #1;
    reset = 1'b0;
    run_seq(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
